counter_cascade: RTL and testbench

Parametrised synchronous loadable up/down counter. It replaces fixed 4-bit-slice counter chains with one WIDTH-bit block, with binary or BCD digit counting, auto-reload for programmable division, and a cascadable ripple-carry output. It serves as the generic counting/divider element in counter and timer designs. Several instances chain through RCO → ENT.

---
 rtl/counter_cascade.sv | 59 +++++
 tb/tb_counter_cascade.sv | 139 +++++++++++++
 2 files changed

// File: rtl/counter_cascade.sv
// counter_cascade: loadable binary/BCD up/down counter with auto-reload, ripple carry and terminal pulse
module counter_cascade #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             nLOAD,
    input  logic             ENP,
    input  logic             ENT,
    input  logic             UP,
    input  logic             BCD,
    input  logic             RELOAD,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Dout,
    output logic             RCO,
    output logic             TCP
);
    localparam int DIGITS = WIDTH / 4;
    logic [WIDTH-1:0] nines, bcd_next, step;
    logic [3:0] nib;
    logic carry, term;
    always_comb begin
        nines = '0;
        bcd_next = Dout;
        carry = 1'b1;
        nib = '0;
        for (int i = 0; i < DIGITS; i++) begin
            nines[4*i+:4] = 4'd9;
            nib = Dout[4*i+:4];
            if (carry) begin
                if (UP) begin
                    bcd_next[4*i+:4] = nib >= 4'd9 ? 4'd0 : nib + 4'd1;
                    carry = nib >= 4'd9;
                end else begin
                    bcd_next[4*i+:4] = nib == 4'd0 ? 4'd9 : nib - 4'd1;
                    carry = nib == 4'd0;
                end
            end
        end
        term = UP ? (BCD ? Dout == nines : &Dout) : Dout == '0;
        step = term ? (RELOAD ? Din : (UP ? '0 : (BCD ? nines : '1)))
                    : (BCD ? bcd_next : (UP ? Dout + WIDTH'(1) : Dout - WIDTH'(1)));
    end
    assign RCO = ENT & term;
    always_ff @(posedge CLK) begin
        if (CLR) begin
            Dout <= '0;
            TCP <= 1'b0;
        end else if (!nLOAD) begin
            Dout <= Din;
            TCP <= 1'b0;
        end else if (ENP && ENT) begin
            Dout <= step;
            TCP <= term;
        end else begin
            TCP <= 1'b0;
        end
    end
endmodule

// File: tb/tb_counter_cascade.sv
// tb_counter_cascade: directed scoreboard bench for single and cascaded counters
module tb_counter_cascade;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;
    logic CLR, nLOAD, ENP, ENT, UP, BCD, RELOAD, RCO, TCP;
    logic [7:0] Din, Dout;
    logic c_clr, c_nload, c_enp, c_up;
    logic [15:0] c_din;
    logic [7:0] lo_dout, hi_dout;
    logic lo_rco, hi_rco, lo_tcp, hi_tcp;
    logic zero = 1'b0;
    logic one = 1'b1;
    counter_cascade #(.WIDTH(8)) dut (
        .CLK(CLK), .CLR(CLR), .nLOAD(nLOAD), .ENP(ENP), .ENT(ENT), .UP(UP), .BCD(BCD),
        .RELOAD(RELOAD), .Din(Din), .Dout(Dout), .RCO(RCO), .TCP(TCP)
    );
    counter_cascade #(.WIDTH(8)) lo (
        .CLK(CLK), .CLR(c_clr), .nLOAD(c_nload), .ENP(c_enp), .ENT(one), .UP(c_up), .BCD(zero),
        .RELOAD(zero), .Din(c_din[7:0]), .Dout(lo_dout), .RCO(lo_rco), .TCP(lo_tcp)
    );
    counter_cascade #(.WIDTH(8)) hi (
        .CLK(CLK), .CLR(c_clr), .nLOAD(c_nload), .ENP(c_enp), .ENT(lo_rco), .UP(c_up), .BCD(zero),
        .RELOAD(zero), .Din(c_din[15:8]), .Dout(hi_dout), .RCO(hi_rco), .TCP(hi_tcp)
    );
    typedef struct {
        string       tag;
        logic [15:0] dout;
        logic        tcp;
    } exp_t;
    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic tick(input string tag, input logic [7:0] d, input logic t);
        exp_t e;
        sb.push_back('{tag, {8'h00, d}, t});
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        check({e.tag, "_dout"}, {8'h00, Dout}, e.dout);
        check({e.tag, "_tcp"}, {15'h0, TCP}, {15'h0, e.tcp});
    endtask
    task automatic tick_c(input string tag, input logic [15:0] d);
        exp_t e;
        sb.push_back('{tag, d, 1'b0});
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        check({e.tag, "_dout16"}, {hi_dout, lo_dout}, e.dout);
    endtask
    initial begin
        CLR = 1; nLOAD = 0; ENP = 1; ENT = 1; Din = 8'h5A; UP = 1; BCD = 0; RELOAD = 0;
        c_clr = 1; c_nload = 1; c_enp = 0; c_up = 1; c_din = 16'h0;
        tick("rst", 8'h00, 0);
        tick("rst2", 8'h00, 0);
        check("rst_rco", {15'h0, RCO}, 16'h0);
        CLR = 0; nLOAD = 1; c_clr = 0;
        tick("cnt1", 8'h01, 0);
        tick("cnt2", 8'h02, 0);
        tick("cnt3", 8'h03, 0);
        nLOAD = 0; Din = 8'hFE;
        tick("ld_fe", 8'hFE, 0);
        nLOAD = 1;
        tick("to_ff", 8'hFF, 0);
        check("rco_ff", {15'h0, RCO}, 16'h1);
        ENT = 0;
        #1;
        check("rco_ent0", {15'h0, RCO}, 16'h0);
        tick("hold_ff", 8'hFF, 0);
        ENT = 1;
        tick("wrap_up", 8'h00, 1);
        tick("tcp_once", 8'h01, 0);
        UP = 0;
        tick("dn_to0", 8'h00, 0);
        check("rco_dn0", {15'h0, RCO}, 16'h1);
        tick("wrap_dn", 8'hFF, 1);
        BCD = 1; UP = 1; nLOAD = 0; Din = 8'h98;
        tick("bcd_ld98", 8'h98, 0);
        nLOAD = 1;
        tick("bcd_99", 8'h99, 0);
        check("bcd_rco99", {15'h0, RCO}, 16'h1);
        tick("bcd_wrap", 8'h00, 1);
        UP = 0; nLOAD = 0; Din = 8'h10;
        tick("bcd_ld10", 8'h10, 0);
        nLOAD = 1;
        tick("bcd_dn09", 8'h09, 0);
        nLOAD = 0; Din = 8'h00;
        tick("bcd_ld00", 8'h00, 0);
        nLOAD = 1;
        tick("bcd_dnwrap", 8'h99, 1);
        nLOAD = 0; Din = 8'h0A;
        tick("bcd_ld0a", 8'h0A, 0);
        nLOAD = 1;
        tick("bcd_dn0a", 8'h09, 0);
        UP = 1; nLOAD = 0; Din = 8'h0C;
        tick("bcd_ld0c", 8'h0C, 0);
        nLOAD = 1;
        tick("bcd_up0c", 8'h10, 0);
        BCD = 0; UP = 0; RELOAD = 1; nLOAD = 0; Din = 8'h04;
        tick("div_ld", 8'h04, 0);
        nLOAD = 1;
        tick("div3", 8'h03, 0);
        tick("div2", 8'h02, 0);
        tick("div1", 8'h01, 0);
        tick("div0", 8'h00, 0);
        tick("div_rl", 8'h04, 1);
        tick("div3b", 8'h03, 0);
        RELOAD = 0; UP = 1; nLOAD = 0; Din = 8'hFF;
        tick("pri_ldff", 8'hFF, 0);
        Din = 8'h33;
        tick("pri_ld33", 8'h33, 0);
        Din = 8'hFF;
        tick("pri_ldff2", 8'hFF, 0);
        nLOAD = 1; CLR = 1;
        tick("pri_clr", 8'h00, 0);
        nLOAD = 0;
        tick("pri_clrld", 8'h00, 0);
        CLR = 0; nLOAD = 1; ENP = 0;
        c_nload = 0; c_din = 16'h00FF;
        tick_c("cas_ld", 16'h00FF);
        c_nload = 1; c_enp = 1;
        tick_c("cas_carry", 16'h0100);
        c_nload = 0; c_din = 16'hFFFF;
        tick_c("cas_ldffff", 16'hFFFF);
        c_nload = 1;
        #1;
        check("cas_hi_rco", {15'h0, hi_rco}, 16'h1);
        tick_c("cas_wrap", 16'h0000);
        check("cas_hi_tcp", {15'h0, hi_tcp}, 16'h1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
